// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encodings, memory op codes and line geometry for the memory arbiter.
package mem_arbiter_pkg;
  localparam int WORD_WIDTH = 32;
  localparam int CACHE_LINE_SIZE = 128;
  localparam logic MEM_OP_READ = 1'b0;
  localparam logic MEM_OP_WRITE = 1'b1;
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IC = 2'd1,
    ARB_BUSY_DC = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_t;
  function automatic int line_offset_bits(input int line_width);
    return $clog2(line_width / 8);
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: icache, dcache and main-memory line ports seen by the arbiter.
interface mem_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int LINE_WIDTH = 128
);
  logic                     ic_req;
  logic [ADDRESS_WIDTH-1:0] ic_addr;
  logic [LINE_WIDTH-1:0]    ic_rdata;
  logic                     ic_ready;
  logic                     dc_req;
  logic                     dc_op;
  logic [ADDRESS_WIDTH-1:0] dc_addr;
  logic [LINE_WIDTH-1:0]    dc_wdata;
  logic [LINE_WIDTH-1:0]    dc_rdata;
  logic                     dc_ready;
  logic                     mem_enable;
  logic                     mem_op;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [LINE_WIDTH-1:0]    mem_wdata;
  logic [LINE_WIDTH-1:0]    mem_rdata;
  logic                     mem_ready;
  modport master (
    input  ic_req, ic_addr, dc_req, dc_op, dc_addr, dc_wdata, mem_rdata, mem_ready,
    output ic_rdata, ic_ready, dc_rdata, dc_ready, mem_enable, mem_op, mem_addr, mem_wdata
  );
  modport slave (
    output ic_req, ic_addr, dc_req, dc_op, dc_addr, dc_wdata, mem_rdata, mem_ready,
    input  ic_rdata, ic_ready, dc_rdata, dc_ready, mem_enable, mem_op, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_starve_counter.sv
// mem_arbiter_starve_counter: saturating count of dcache grants taken while an icache fill waits.
module mem_arbiter_starve_counter #(
  parameter int LIMIT = 4,
  parameter int W = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         at_limit
);
  assign at_limit = count == W'(LIMIT);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clr) count <= '0;
    else if (inc && !at_limit) count <= count + 1'b1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises icache fills and dcache fills/write-backs onto one memory line port.
// Dcache has priority; the starve counter forces an icache grant after STARVE_LIMIT dcache wins.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic reset,
  mem_arbiter_if.master bus
);
  localparam int OFFSET = line_offset_bits(LINE_WIDTH);
  arb_state_t state, next_state;
  logic grant_dc, grant_ic, done, at_limit;
  logic [ADDRESS_WIDTH-1:0] grant_addr;
  logic [$clog2(STARVE_LIMIT + 1)-1:0] starve_count;
  assign grant_dc = state == ARB_IDLE && bus.dc_req && (!bus.ic_req || !at_limit);
  assign grant_ic = state == ARB_IDLE && bus.ic_req && !grant_dc;
  assign done = bus.mem_ready && (state == ARB_BUSY_IC || state == ARB_BUSY_DC);
  assign grant_addr = grant_dc ? bus.dc_addr : bus.ic_addr;
  mem_arbiter_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk(clk),
    .reset(reset),
    .inc(grant_dc && bus.ic_req),
    .clr(grant_ic || (grant_dc && !bus.ic_req)),
    .count(starve_count),
    .at_limit(at_limit)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ARB_IDLE;
    else state <= next_state;
  always_comb
    next_state = grant_dc             ? ARB_BUSY_DC :
                 grant_ic             ? ARB_BUSY_IC :
                 done                 ? ARB_RELEASE :
                 state == ARB_RELEASE ? ARB_IDLE    : state;
  // Transaction fields are latched at grant so requesters may change inputs afterwards.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.mem_enable <= 1'b0;
      bus.mem_op <= MEM_OP_READ;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.ic_ready <= 1'b0;
      bus.dc_ready <= 1'b0;
      bus.ic_rdata <= '0;
      bus.dc_rdata <= '0;
    end else begin
      bus.ic_ready <= done && state == ARB_BUSY_IC;
      bus.dc_ready <= done && state == ARB_BUSY_DC;
      if (grant_dc || grant_ic) begin
        bus.mem_enable <= 1'b1;
        bus.mem_op <= grant_dc ? bus.dc_op : MEM_OP_READ;
        bus.mem_addr <= {grant_addr[ADDRESS_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
        bus.mem_wdata <= grant_dc ? bus.dc_wdata : '0;
      end else if (done) bus.mem_enable <= 1'b0;
      if (done && state == ARB_BUSY_IC) bus.ic_rdata <= bus.mem_rdata;
      if (done && state == ARB_BUSY_DC && bus.mem_op == MEM_OP_READ) bus.dc_rdata <= bus.mem_rdata;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant order, latching, ready pulses, starvation and reset.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  localparam logic [127:0] DEAD = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] D1 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] I1 = 128'hA5A5A5A5_0F0F0F0F_12345678_9ABCDEF0;
  mem_arbiter_if #(.ADDRESS_WIDTH(32), .LINE_WIDTH(128)) bus ();
  mem_arbiter #(.ADDRESS_WIDTH(32), .LINE_WIDTH(128), .STARVE_LIMIT(4)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic respond(input logic [127:0] data);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = data;
    tick();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
  endtask
  initial begin
    bus.ic_req = 0; bus.ic_addr = '0;
    bus.dc_req = 0; bus.dc_op = 0; bus.dc_addr = '0; bus.dc_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ready = 0;
    tick(); tick();
    check("reset_enable", bus.mem_enable, 0);
    check("reset_ic_rdata", bus.ic_rdata, 0);
    check("reset_dc_rdata", bus.dc_rdata, 0);
    reset = 1'b0;
    // reset in the middle of an icache fill
    bus.ic_req = 1; bus.ic_addr = 32'h40;
    tick();
    check("t1_enable", bus.mem_enable, 1);
    check("t1_addr", bus.mem_addr, 32'h40);
    tick(); tick();
    reset = 1'b1; bus.ic_req = 0;
    #1;
    check("t1_async_enable", bus.mem_enable, 0);
    check("t1_async_addr", bus.mem_addr, 0);
    tick();
    reset = 1'b0;
    respond(DEAD);
    check("t1_late_ready", bus.ic_ready, 0);
    check("t1_late_rdata", bus.ic_rdata, 0);
    check("t1_late_enable", bus.mem_enable, 0);
    // icache fill alone, memory answers after 5 cycles
    bus.ic_req = 1; bus.ic_addr = 32'h1C;
    tick();
    check("t2_enable", bus.mem_enable, 1);
    check("t2_addr", bus.mem_addr, 32'h10);
    check("t2_op", bus.mem_op, 0);
    bus.ic_addr = 32'hFFF0;
    tick(); tick(); tick(); tick();
    check("t2_held_addr", bus.mem_addr, 32'h10);
    check("t2_no_early_ready", bus.ic_ready, 0);
    respond(DEAD);
    check("t2_ready", bus.ic_ready, 1);
    check("t2_rdata", bus.ic_rdata, DEAD);
    check("t2_release_enable", bus.mem_enable, 0);
    bus.ic_req = 0;
    tick();
    check("t2_ready_pulse_end", bus.ic_ready, 0);
    check("t2_idle_enable", bus.mem_enable, 0);
    // simultaneous requests: dcache first, icache 3 cycles after mem_ready
    bus.ic_req = 1; bus.ic_addr = 32'h100;
    bus.dc_req = 1; bus.dc_op = 0; bus.dc_addr = 32'h234;
    tick();
    check("t4_dc_addr", bus.mem_addr, 32'h230);
    check("t4_dc_op", bus.mem_op, 0);
    check("t4_starve1", dut.u_starve.count, 1);
    tick();
    respond(D1);
    check("t4_dc_ready", bus.dc_ready, 1);
    check("t4_dc_rdata", bus.dc_rdata, D1);
    check("t4_ic_not_ready", bus.ic_ready, 0);
    bus.dc_req = 0;
    tick();
    check("t4_gap_enable", bus.mem_enable, 0);
    tick();
    check("t4_ic_enable", bus.mem_enable, 1);
    check("t4_ic_addr", bus.mem_addr, 32'h100);
    check("t4_starve0", dut.u_starve.count, 0);
    respond(I1);
    check("t4_ic_ready", bus.ic_ready, 1);
    check("t4_ic_rdata", bus.ic_rdata, I1);
    bus.ic_req = 0;
    tick();
    // dcache write-back
    bus.dc_req = 1; bus.dc_op = 1; bus.dc_addr = 32'h08; bus.dc_wdata = 128'h2;
    tick();
    check("t3_op", bus.mem_op, 1);
    check("t3_addr", bus.mem_addr, 0);
    check("t3_wdata", bus.mem_wdata, 128'h2);
    bus.dc_wdata = 128'hFFFF; bus.dc_op = 0;
    tick();
    check("t3_wdata_held", bus.mem_wdata, 128'h2);
    check("t3_op_held", bus.mem_op, 1);
    respond(128'hBAD);
    check("t3_ready", bus.dc_ready, 1);
    check("t3_rdata_kept", bus.dc_rdata, D1);
    bus.dc_req = 0;
    tick();
    check("t3_ready_pulse_end", bus.dc_ready, 0);
    // continuous dcache traffic against a pending icache fill
    bus.ic_req = 1; bus.ic_addr = 32'h500;
    bus.dc_req = 1; bus.dc_op = 0; bus.dc_addr = 32'h600;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t5_dc_addr%0d", k), bus.mem_addr, 32'h600 + 32'(k * 16));
      check($sformatf("t5_starve%0d", k), dut.u_starve.count, 128'(k + 1));
      respond(D1 + 128'(k));
      check($sformatf("t5_dc_ready%0d", k), bus.dc_ready, 1);
      check($sformatf("t5_ic_wait%0d", k), bus.ic_ready, 0);
      bus.dc_addr = 32'h600 + 32'((k + 1) * 16);
      tick();
    end
    tick();
    check("t5_ic_grant", bus.mem_addr, 32'h500);
    check("t5_starve_clear", dut.u_starve.count, 0);
    bus.dc_req = 0;
    respond(DEAD);
    check("t5_ic_ready", bus.ic_ready, 1);
    check("t5_dc_rdata", bus.dc_rdata, D1 + 128'd3);
    bus.ic_req = 0;
    tick();
    // spurious mem_ready while idle
    for (int k = 0; k < 3; k++) begin
      respond(I1 ^ 128'(k + 1));
      check($sformatf("t6_ic_ready%0d", k), bus.ic_ready, 0);
      check($sformatf("t6_dc_ready%0d", k), bus.dc_ready, 0);
      check($sformatf("t6_enable%0d", k), bus.mem_enable, 0);
    end
    check("t6_ic_rdata", bus.ic_rdata, DEAD);
    check("t6_dc_rdata", bus.dc_rdata, D1 + 128'd3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
